// File: rtl/cpu_bus_cycle_gen.sv
// Sequences core requests into 8088 minimum-mode bus cycles (T1/T2/T3/Tw/T4, S2..S0, LOCK).
// Optional macro BUS_TIMEOUT_EN bounds Tw with TIMEOUT_CYCLES and reports aborts on rsp_error.
module cpu_bus_cycle_gen #(
`ifdef BUS_TIMEOUT_EN
  parameter int TIMEOUT_CYCLES = 1023,
`endif
  parameter int INTA_GAP = 2
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        cpu_clock_en,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_status,
  input  logic [19:0] req_address,
  input  logic [7:0]  req_wdata,
  input  logic        req_lock,
  output logic        rsp_valid,
  output logic [7:0]  rsp_rdata,
  output logic        rsp_error,
  output logic [19:0] cpu_address,
  output logic [7:0]  cpu_data_bus,
  output logic [2:0]  processor_status,
  output logic        processor_lock_n,
  input  logic        processor_ready,
  input  logic [7:0]  data_bus_in
);

  typedef enum logic [2:0] {ST_TI, ST_T1, ST_T2, ST_T3, ST_TW, ST_T4, ST_TGAP} state_t;

  localparam logic [2:0] STAT_INTA    = 3'b000;
  localparam logic [2:0] STAT_IOW     = 3'b010;
  localparam logic [2:0] STAT_HALT    = 3'b011;
  localparam logic [2:0] STAT_MEMW    = 3'b110;
  localparam logic [2:0] STAT_PASSIVE = 3'b111;

  state_t      state, state_nxt;
  logic [2:0]  cyc_status, cyc_status_nxt;
  logic [7:0]  cyc_wdata, cyc_wdata_nxt;
  logic        inta_second, inta_second_nxt;
  logic [7:0]  gap_cnt, gap_cnt_nxt;
  logic [19:0] address_nxt;
  logic [7:0]  data_nxt, rdata_nxt;
  logic [2:0]  status_nxt;
  logic        lock_n_nxt, rsp_valid_nxt;
  logic        abort;
  logic        inta_first, cycle_is_read, cycle_is_write, take, start_second;
`ifdef BUS_TIMEOUT_EN
  logic        abort_nxt, rsp_error_nxt;
  logic [9:0]  wait_cnt, wait_cnt_nxt;
`else
  assign abort     = 1'b0;
  assign rsp_error = 1'b0;
`endif

  assign cycle_is_write = (cyc_status == STAT_IOW) || (cyc_status == STAT_MEMW);
  assign cycle_is_read  = cyc_status inside {3'b000, 3'b001, 3'b100, 3'b101};
  // The first INTA cycle keeps LOCK and must not return a response or accept new work.
  assign inta_first     = (cyc_status == STAT_INTA) && !inta_second && !abort;
  assign take           = cpu_clock_en && req_valid &&
                          ((state == ST_TI) || ((state == ST_T4) && !inta_first));
  assign req_ready      = take && reset_n;

  always_comb begin
    state_nxt       = state;
    cyc_status_nxt  = cyc_status;
    cyc_wdata_nxt   = cyc_wdata;
    inta_second_nxt = inta_second;
    gap_cnt_nxt     = gap_cnt;
    address_nxt     = cpu_address;
    data_nxt        = cpu_data_bus;
    rdata_nxt       = rsp_rdata;
    status_nxt      = processor_status;
    lock_n_nxt      = processor_lock_n;
    rsp_valid_nxt   = 1'b0;
    start_second    = 1'b0;
`ifdef BUS_TIMEOUT_EN
    abort_nxt       = abort;
    wait_cnt_nxt    = wait_cnt;
    rsp_error_nxt   = rsp_error;
`endif
    if (cpu_clock_en) begin
      case (state)
        ST_T1: begin
          if (cyc_status == STAT_HALT) begin
            status_nxt    = STAT_PASSIVE;
            lock_n_nxt    = 1'b1;
            rsp_valid_nxt = 1'b1;
`ifdef BUS_TIMEOUT_EN
            rsp_error_nxt = 1'b0;
`endif
            state_nxt     = ST_TI;
          end else begin
            if (cycle_is_write) data_nxt = cyc_wdata;
            state_nxt = ST_T2;
          end
        end
        ST_T2: begin
          status_nxt = STAT_PASSIVE;
          state_nxt  = ST_T3;
        end
        ST_T3, ST_TW: begin
          if (processor_ready) begin
            if (cycle_is_read && !inta_first) rdata_nxt = data_bus_in;
            state_nxt = ST_T4;
          end
`ifdef BUS_TIMEOUT_EN
          else if ((state == ST_TW) && (wait_cnt >= 10'(TIMEOUT_CYCLES))) begin
            abort_nxt = 1'b1;
            state_nxt = ST_T4;
          end
`endif
          else begin
`ifdef BUS_TIMEOUT_EN
            wait_cnt_nxt = wait_cnt + 10'd1;
`endif
            state_nxt = ST_TW;
          end
        end
        ST_T4: begin
          if (inta_first) begin
            if (INTA_GAP == 0) begin
              start_second = 1'b1;
            end else begin
              gap_cnt_nxt = 8'd1;
              state_nxt   = ST_TGAP;
            end
          end else begin
            rsp_valid_nxt = 1'b1;
`ifdef BUS_TIMEOUT_EN
            rsp_error_nxt = abort;
`endif
            lock_n_nxt    = 1'b1;
            state_nxt     = ST_TI;
          end
        end
        ST_TGAP: begin
          if (gap_cnt >= 8'(INTA_GAP)) start_second = 1'b1;
          else gap_cnt_nxt = gap_cnt + 8'd1;
        end
        default: ;
      endcase

      if (start_second) begin
        status_nxt      = cyc_status;
        lock_n_nxt      = 1'b1;
        inta_second_nxt = 1'b1;
`ifdef BUS_TIMEOUT_EN
        wait_cnt_nxt    = 10'd0;
`endif
        state_nxt       = ST_T1;
      end

      // An accepted request overrides the T4 release so back-to-back cycles skip TI.
      if (take) begin
        cyc_status_nxt  = req_status;
        cyc_wdata_nxt   = req_wdata;
        inta_second_nxt = 1'b0;
        gap_cnt_nxt     = 8'd0;
        address_nxt     = req_address;
        status_nxt      = req_status;
        lock_n_nxt      = (req_status == STAT_INTA) ? 1'b0 : ~req_lock;
`ifdef BUS_TIMEOUT_EN
        abort_nxt       = 1'b0;
        wait_cnt_nxt    = 10'd0;
`endif
        state_nxt       = ST_T1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state            <= ST_TI;
      cyc_status       <= STAT_PASSIVE;
      cyc_wdata        <= 8'd0;
      inta_second      <= 1'b0;
      gap_cnt          <= 8'd0;
      cpu_address      <= 20'd0;
      cpu_data_bus     <= 8'd0;
      rsp_rdata        <= 8'd0;
      processor_status <= STAT_PASSIVE;
      processor_lock_n <= 1'b1;
      rsp_valid        <= 1'b0;
`ifdef BUS_TIMEOUT_EN
      abort            <= 1'b0;
      wait_cnt         <= 10'd0;
      rsp_error        <= 1'b0;
`endif
    end else begin
      state            <= state_nxt;
      cyc_status       <= cyc_status_nxt;
      cyc_wdata        <= cyc_wdata_nxt;
      inta_second      <= inta_second_nxt;
      gap_cnt          <= gap_cnt_nxt;
      cpu_address      <= address_nxt;
      cpu_data_bus     <= data_nxt;
      rsp_rdata        <= rdata_nxt;
      processor_status <= status_nxt;
      processor_lock_n <= lock_n_nxt;
      rsp_valid        <= rsp_valid_nxt;
`ifdef BUS_TIMEOUT_EN
      abort            <= abort_nxt;
      wait_cnt         <= wait_cnt_nxt;
      rsp_error        <= rsp_error_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_cpu_bus_cycle_gen.sv
// Randomized directed bench for cpu_bus_cycle_gen; expected T-state traces come from a bus-cycle model.
// Timeout steps compile in only when BUS_TIMEOUT_EN is defined.
module tb_cpu_bus_cycle_gen;

  localparam int TB_GAP     = 2;
  localparam int TB_TIMEOUT = 4;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        cpu_clock_en = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  req_status = 3'b111;
  logic [19:0] req_address = 20'd0;
  logic [7:0]  req_wdata = 8'd0;
  logic        req_lock = 1'b0;
  logic        rsp_valid;
  logic [7:0]  rsp_rdata;
  logic        rsp_error;
  logic [19:0] cpu_address;
  logic [7:0]  cpu_data_bus;
  logic [2:0]  processor_status;
  logic        processor_lock_n;
  logic        processor_ready = 1'b0;
  logic [7:0]  data_bus_in = 8'd0;

  always #5 clock = ~clock;

`ifdef BUS_TIMEOUT_EN
  cpu_bus_cycle_gen #(.TIMEOUT_CYCLES(TB_TIMEOUT), .INTA_GAP(TB_GAP)) dut (
`else
  cpu_bus_cycle_gen #(.INTA_GAP(TB_GAP)) dut (
`endif
    .clock(clock), .reset_n(reset_n), .cpu_clock_en(cpu_clock_en),
    .req_valid(req_valid), .req_ready(req_ready), .req_status(req_status),
    .req_address(req_address), .req_wdata(req_wdata), .req_lock(req_lock),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
    .cpu_address(cpu_address), .cpu_data_bus(cpu_data_bus),
    .processor_status(processor_status), .processor_lock_n(processor_lock_n),
    .processor_ready(processor_ready), .data_bus_in(data_bus_in));

  typedef struct {
    logic [2:0] status;
    logic       lock_n;
    logic       ready;
    logic [7:0] dbus;
    logic       chk_wdata;
  } tstate_t;

  typedef struct {
    logic [2:0]  status;
    logic [19:0] addr;
    logic [7:0]  wdata;
    logic        lock;
    int          waits1;
    int          waits2;
    logic [7:0]  d1;
    logic [7:0]  d2;
    logic        timeout;
  } req_t;

  tstate_t exp_q[$];
  req_t    reqs[$];
  int      checks = 0;
  int      failures = 0;
  int      cur_gap = 0;
  logic [7:0] exp_rdata = 8'd0;
  logic       exp_err = 1'b0;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic req_t mkReq(logic [2:0] st, logic [19:0] a, logic [7:0] w, logic lk,
                                 int w1, int w2, logic [7:0] d1, logic [7:0] d2, logic to);
    req_t r;
    r.status = st; r.addr = a; r.wdata = w; r.lock = lk;
    r.waits1 = w1; r.waits2 = w2; r.d1 = d1; r.d2 = d2; r.timeout = to;
    return r;
  endfunction

  function automatic req_t randReq();
    return mkReq(3'($urandom_range(6, 0)), 20'($urandom), 8'($urandom), 1'($urandom),
                 int'($urandom_range(3, 0)), int'($urandom_range(3, 0)),
                 8'($urandom), 8'($urandom), 1'b0);
  endfunction

  function automatic int gapv();
    return (cur_gap < 0) ? int'($urandom_range(2, 0)) : cur_gap;
  endfunction

  // One full bus cycle: T1, T2, T3, Tw*n, T4; READY is honoured only in T3/Tw.
  task automatic pushCycle(input logic [2:0] st, input logic lk_n, input int waits,
                           input logic [7:0] d, input logic to, input logic wr);
    tstate_t t;
    int nw;
    nw = to ? TB_TIMEOUT : waits;
    t.status = st; t.lock_n = lk_n; t.ready = 1'($urandom); t.dbus = 8'($urandom);
    t.chk_wdata = 1'b0;
    exp_q.push_back(t);
    t.ready = 1'($urandom); t.dbus = 8'($urandom); t.chk_wdata = wr;
    exp_q.push_back(t);
    t.status = 3'b111;
    for (int j = 0; j <= nw; j++) begin
      t.ready = (j == nw) && !to;
      t.dbus  = t.ready ? d : 8'($urandom);
      exp_q.push_back(t);
    end
    t.ready = 1'($urandom); t.dbus = 8'($urandom);
    exp_q.push_back(t);
  endtask

  task automatic buildModel(input req_t r);
    tstate_t t;
    logic wr;
    exp_q.delete();
    exp_err = r.timeout;
    wr = (r.status == 3'b010) || (r.status == 3'b110);
    if (r.status == 3'b011) begin
      t.status = 3'b011; t.lock_n = ~r.lock; t.ready = 1'($urandom);
      t.dbus = 8'($urandom); t.chk_wdata = 1'b0;
      exp_q.push_back(t);
    end else if (r.status == 3'b000) begin
      pushCycle(3'b000, 1'b0, r.waits1, r.d1, r.timeout, 1'b0);
      if (!r.timeout) begin
        for (int g = 0; g < TB_GAP; g++) begin
          t.status = 3'b111; t.lock_n = 1'b0; t.ready = 1'($urandom);
          t.dbus = 8'($urandom); t.chk_wdata = 1'b0;
          exp_q.push_back(t);
        end
        pushCycle(3'b000, 1'b1, r.waits2, r.d2, 1'b0, 1'b0);
        exp_rdata = r.d2;
      end
    end else begin
      pushCycle(r.status, ~r.lock, r.waits1, r.d1, r.timeout, wr);
      if (!r.timeout && (r.status inside {3'b001, 3'b100, 3'b101})) exp_rdata = r.d1;
    end
  endtask

  task automatic setReq(input req_t r);
    req_status = r.status; req_address = r.addr; req_wdata = r.wdata; req_lock = r.lock;
  endtask

  task automatic junkReq();
    req_status = 3'($urandom); req_address = 20'($urandom);
    req_wdata = 8'($urandom); req_lock = 1'($urandom);
  endtask

  task automatic idleClocks(input int n);
    logic [40:0] snap;
    snap = {processor_status, processor_lock_n, cpu_address, cpu_data_bus, rsp_rdata, rsp_error};
    for (int c = 0; c < n; c++) begin
      @(posedge clock); #1;
      checkOutput("frozen", 64'({rsp_valid, req_ready, processor_status, processor_lock_n,
                                 cpu_address, cpu_data_bus, rsp_rdata, rsp_error}),
                  64'({2'b00, snap}));
    end
  endtask

  task automatic enabledEdge();
    @(posedge clock); #1;
    cpu_clock_en = 1'b0;
    req_valid = 1'b0;
    junkReq();
  endtask

  // Runs the queued requests back to back (HALT always returns to TI).
  task automatic applyStimulus(input int gap);
    req_t r;
    tstate_t e;
    logic b2b;
    cur_gap = gap;
    for (int k = 0; k < reqs.size(); k++) begin
      r = reqs[k];
      buildModel(r);
      if (k == 0 || reqs[k-1].status == 3'b011) begin
        setReq(r);
        req_valid = 1'b1;
        idleClocks(gapv());
        cpu_clock_en = 1'b1;
        #1 checkOutput("req_ready_ti", 64'(req_ready), 64'd1);
        enabledEdge();
      end
      b2b = 1'b0;
      for (int i = 0; i < exp_q.size(); i++) begin
        e = exp_q[i];
        checkOutput("status", 64'(processor_status), 64'(e.status));
        checkOutput("lock_n", 64'(processor_lock_n), 64'(e.lock_n));
        checkOutput("address", 64'(cpu_address), 64'(r.addr));
        if (e.chk_wdata) checkOutput("wdata", 64'(cpu_data_bus), 64'(r.wdata));
        if (i > 0) checkOutput("rsp_idle", 64'(rsp_valid), 64'd0);
        processor_ready = e.ready;
        data_bus_in = e.dbus;
        b2b = (i == exp_q.size() - 1) && (k + 1 < reqs.size()) && (r.status != 3'b011);
        if (b2b) begin
          setReq(reqs[k+1]);
          req_valid = 1'b1;
        end else if (i == exp_q.size() - 1 && r.status != 3'b011) begin
          req_valid = 1'b0;
        end else begin
          req_valid = 1'($urandom);
        end
        idleClocks(gapv());
        cpu_clock_en = 1'b1;
        #1 checkOutput("req_ready", 64'(req_ready), 64'(b2b));
        enabledEdge();
      end
      checkOutput("rsp_valid", 64'(rsp_valid), 64'd1);
      checkOutput("rsp_rdata", 64'(rsp_rdata), 64'(exp_rdata));
      checkOutput("rsp_error", 64'(rsp_error), 64'(exp_err));
      if (!b2b) begin
        checkOutput("ti_status", 64'(processor_status), 64'(3'b111));
        checkOutput("ti_lock_n", 64'(processor_lock_n), 64'd1);
      end
    end
    reqs.delete();
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired before the bench completed");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    // Reset with a request pending: nothing may be accepted.
    setReq(mkReq(3'b101, 20'hFE000, 8'h00, 1'b0, 0, 0, 8'h00, 8'h00, 1'b0));
    req_valid = 1'b1;
    cpu_clock_en = 1'b1;
    reset_n = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clock); #1;
      checkOutput("reset_state", 64'({processor_status, processor_lock_n, cpu_address,
                  cpu_data_bus, rsp_rdata, rsp_valid, rsp_error, req_ready}),
                  64'({3'b111, 1'b1, 20'd0, 8'd0, 8'd0, 3'b000}));
    end
    req_valid = 1'b0;
    reset_n = 1'b1;
    @(posedge clock); #1;
    cpu_clock_en = 1'b0;
    checkOutput("post_reset_idle", 64'({processor_status, rsp_valid}), 64'({3'b111, 1'b0}));

    $display("[TB] MEMR with immediate READY");
    reqs.push_back(mkReq(3'b101, 20'hFE000, 8'h00, 1'b0, 0, 0, 8'hEA, 8'h00, 1'b0));
    applyStimulus(-1);

    $display("[TB] IOW with two wait states");
    reqs.push_back(mkReq(3'b010, 20'h00061, 8'h4B, 1'b0, 2, 0, 8'h00, 8'h00, 1'b0));
    applyStimulus(-1);

    $display("[TB] INTA pair");
    reqs.push_back(mkReq(3'b000, 20'h00000, 8'h00, 1'b0, 1, 0, 8'h11, 8'h08, 1'b0));
    applyStimulus(-1);

    $display("[TB] back-to-back MEMW then MEMR, enable every third clock");
    reqs.push_back(mkReq(3'b110, 20'h12345, 8'hA5, 1'b1, 1, 0, 8'h00, 8'h00, 1'b0));
    reqs.push_back(mkReq(3'b101, 20'h54321, 8'h00, 1'b0, 0, 0, 8'h3C, 8'h00, 1'b0));
    applyStimulus(2);

    $display("[TB] HALT");
    reqs.push_back(mkReq(3'b011, 20'h0ABCD, 8'h00, 1'b1, 0, 0, 8'h00, 8'h00, 1'b0));
    applyStimulus(-1);

    $display("[TB] randomized request groups");
    for (int g = 0; g < 10; g++) begin
      for (int n = 0; n < int'($urandom_range(3, 1)); n++) reqs.push_back(randReq());
      applyStimulus(-1);
    end

    $display("[TB] reset during Tw of a locked IOR");
    setReq(mkReq(3'b001, 20'h003F8, 8'h00, 1'b1, 0, 0, 8'h00, 8'h00, 1'b0));
    req_valid = 1'b1;
    processor_ready = 1'b0;
    cpu_clock_en = 1'b1;
    @(posedge clock); #1;
    req_valid = 1'b0;
    junkReq();
    repeat (3) @(posedge clock);
    #1 checkOutput("pre_reset_lock", 64'({processor_status, processor_lock_n}), 64'({3'b111, 1'b0}));
    reset_n = 1'b0;
    @(posedge clock); #1;
    reset_n = 1'b1;
    processor_ready = 1'b1;
    data_bus_in = 8'h77;
    checkOutput("reset_in_tw", 64'({processor_status, processor_lock_n, cpu_address, rsp_rdata, rsp_valid}),
                64'({3'b111, 1'b1, 20'd0, 8'd0, 1'b0}));
    for (int c = 0; c < 8; c++) begin
      @(posedge clock); #1;
      checkOutput("dropped_cycle", 64'({processor_status, rsp_valid}), 64'({3'b111, 1'b0}));
    end
    cpu_clock_en = 1'b0;
    exp_rdata = 8'd0;

`ifdef BUS_TIMEOUT_EN
    $display("[TB] READY stuck low timeouts");
    reqs.push_back(mkReq(3'b001, 20'h00060, 8'h00, 1'b1, 0, 0, 8'h00, 8'h00, 1'b1));
    applyStimulus(0);
    reqs.push_back(mkReq(3'b000, 20'h00000, 8'h00, 1'b0, 0, 0, 8'h00, 8'h00, 1'b1));
    applyStimulus(1);
    reqs.push_back(mkReq(3'b101, 20'hF0000, 8'h00, 1'b0, 3, 0, 8'h5A, 8'h00, 1'b0));
    applyStimulus(-1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
